histogram_system_top: RTL and testbench

//  AXI-Lite-controlled 8-bit LFSR sample generator with an on-chip 8-bin histogram.
//  - Software programs the seed and taps, then starts and stops generation.
//  - Each sample is binned by value range; its bin counter is incremented in an internal RAM.
//  - A debug port reads the RAM directly. Top level of the histogram subsystem.

---
 rtl/histogram_system_pkg.sv | 33 +++
 rtl/histogram_system_top_lfsr.sv | 36 +++
 rtl/histogram_system_top.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_histogram_system_top.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_system_pkg.sv
// Shared definitions for the LFSR histogram subsystem: register offsets,
// bin geometry, AXI response code, FSM state encodings and the binning function.
package histogram_system_pkg;

  localparam logic [3:0] ADDR_START = 4'h0;
  localparam logic [3:0] ADDR_STOP  = 4'h4;
  localparam logic [3:0] ADDR_SEED  = 4'h8;
  localparam logic [3:0] ADDR_TAPS  = 4'hC;

  localparam int NUM_BINS  = 8;
  localparam int BIN_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic RD_IDLE = 1'b0;
  localparam logic RD_DATA = 1'b1;

  // Values 0..32 share bin 0; above that each bin spans 32 values.
  function automatic logic [2:0] bin_of(input logic [7:0] v);
    logic [7:0] v_m1;
    v_m1 = v - 8'd1;
    if (v <= 8'd32) begin
      return 3'd0;
    end else begin
      return v_m1[7:5];
    end
  endfunction

endpackage

// File: rtl/histogram_system_top_lfsr.sv
// hist_lfsr8: 8-bit Galois right-shift LFSR with seed load and step enable.
module hist_lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  input  logic [7:0] taps,
  output logic [7:0] state
);

  logic [7:0] state_q, state_d;

  // Load has priority over stepping.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ taps) : (state_q >> 1);
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 8'h01;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/histogram_system_top.sv
// AXI-Lite controlled LFSR sample generator with an 8-bin histogram RAM.
// Optional HIST_CLEAR_ON_START_EN: START zeroes the counter words before sampling.
module histogram_system_top
  import histogram_system_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 4,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH  = 8,
  parameter int RAM_DATA_WIDTH  = 32,
  parameter int SAMPLE_DIV      = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [RAM_ADDR_WIDTH-1:0]  debug_addr,
  input  logic                       debug_rd_en,
  output logic [RAM_DATA_WIDTH-1:0]  debug_rdata
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [1:0]                 wr_state_q, wr_state_d;
  logic [1:0]                 awreg_q, awreg_d;
  logic                       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                       rd_state_q, rd_state_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]                 seed_q, seed_d, taps_q, taps_d, lfsr_s;
  logic                       running_q, running_d, start_s, step_s;
  logic [DIV_W-1:0]           div_q, div_d;
  logic                       clr_act_q, clr_act_d;
  logic [2:0]                 clr_idx_q, clr_idx_d;
  logic                       samp_vld_q, samp_vld_d, rmw_pend_q, rmw_pend_d;
  logic [RAM_ADDR_WIDTH-1:0]  rmw_addr_q, rmw_addr_d, samp_addr_s;
  logic [RAM_DATA_WIDTH-1:0]  rmw_cnt_q, rmw_cnt_d, debug_rdata_q, debug_rdata_d;
  logic                       ram_we_s;
  logic [RAM_ADDR_WIDTH-1:0]  ram_waddr_s;
  logic [RAM_DATA_WIDTH-1:0]  ram_wdata_s;
  logic [RAM_DATA_WIDTH-1:0]  ram_q [0:(1<<RAM_ADDR_WIDTH)-1];
  logic                       unused_in_s;

  assign unused_in_s = ^{s_axi_wdata[AXIL_DATA_WIDTH-1:8], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Write channel FSM and register file.
  always_comb begin
    wr_state_d = wr_state_q;
    awreg_d    = awreg_q;
    seed_d     = seed_q;
    taps_d     = taps_q;
    running_d  = running_q;
    start_s    = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          awreg_d    = s_axi_awaddr[3:2];
          wr_state_d = WR_DATA;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          wr_state_d = WR_RESP;
          case ({awreg_q, 2'b00})
            ADDR_START: begin
              if (s_axi_wdata[0]) begin
                running_d = 1'b1;
                start_s   = 1'b1;
              end else begin
                running_d = running_q;
              end
            end
            ADDR_STOP: begin
              if (s_axi_wdata[0]) begin
                running_d = 1'b0;
              end else begin
                running_d = running_q;
              end
            end
            ADDR_SEED: seed_d = (s_axi_wdata[7:0] == 8'h00) ? 8'h01 : s_axi_wdata[7:0];
            ADDR_TAPS: taps_d = s_axi_wdata[7:0];
            default:   taps_d = taps_q;
          endcase
        end else begin
          wr_state_d = WR_DATA;
        end
      end
      WR_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_RESP;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    awready_d = (wr_state_d == WR_IDLE);
    wready_d  = (wr_state_d == WR_DATA);
    bvalid_d  = (wr_state_d == WR_RESP);
  end

  // Read channel FSM; rdata is captured at the AR handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rd_state_d = RD_DATA;
          case ({s_axi_araddr[3:2], 2'b00})
            ADDR_START: rdata_d = {{(AXIL_DATA_WIDTH-1){1'b0}}, running_q};
            ADDR_SEED:  rdata_d = {{(AXIL_DATA_WIDTH-8){1'b0}}, seed_q};
            ADDR_TAPS:  rdata_d = {{(AXIL_DATA_WIDTH-8){1'b0}}, taps_q};
            default:    rdata_d = {AXIL_DATA_WIDTH{1'b0}};
          endcase
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_DATA: begin
        if (s_axi_rready && rvalid_q) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_DATA;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
    rvalid_d  = (rd_state_d == RD_DATA);
  end

  // Sample pacing; an optional clear sweep holds off sampling after START.
  always_comb begin
    div_d     = div_q;
    step_s    = 1'b0;
    clr_act_d = clr_act_q;
    clr_idx_d = clr_idx_q;
    if (start_s) begin
      div_d = {DIV_W{1'b0}};
`ifdef HIST_CLEAR_ON_START_EN
      clr_act_d = 1'b1;
      clr_idx_d = 3'd0;
`else
      clr_act_d = 1'b0;
`endif
    end else if (clr_act_q) begin
      clr_idx_d = clr_idx_q + 3'd1;
      clr_act_d = (clr_idx_q != 3'd7);
    end else if (running_q) begin
      if (div_q == DIV_LAST) begin
        div_d  = {DIV_W{1'b0}};
        step_s = 1'b1;
      end else begin
        div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      div_d = div_q;
    end
  end

  hist_lfsr8 u_lfsr (
    .clk   (aclk),
    .rst_n (aresetn),
    .load  (start_s),
    .seed  (seed_q),
    .step  (step_s),
    .taps  (taps_q),
    .state (lfsr_s)
  );

  assign samp_addr_s = {{(RAM_ADDR_WIDTH-5){1'b0}}, bin_of(lfsr_s), 2'b00};

  // Read-modify-write: read the bin the cycle after a step, write back the next cycle.
  always_comb begin
    samp_vld_d = step_s;
    rmw_pend_d = samp_vld_q;
    rmw_addr_d = rmw_addr_q;
    rmw_cnt_d  = rmw_cnt_q;
    if (samp_vld_q) begin
      rmw_addr_d = samp_addr_s;
      rmw_cnt_d  = ram_q[samp_addr_s];
    end else begin
      rmw_cnt_d = rmw_cnt_q;
    end
    ram_we_s    = 1'b0;
    ram_waddr_s = rmw_addr_q;
    ram_wdata_s = rmw_cnt_q + {{(RAM_DATA_WIDTH-1){1'b0}}, 1'b1};
    if (clr_act_q) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = {{(RAM_ADDR_WIDTH-5){1'b0}}, clr_idx_q, 2'b00};
      ram_wdata_s = {RAM_DATA_WIDTH{1'b0}};
    end else if (rmw_pend_q) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
    if (debug_rd_en) begin
      debug_rdata_d = ram_q[debug_addr];
    end else begin
      debug_rdata_d = debug_rdata_q;
    end
  end

  // Histogram storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (ram_we_s) begin
      ram_q[ram_waddr_s] <= ram_wdata_s;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q    <= WR_IDLE;
      awreg_q       <= 2'b00;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      rd_state_q    <= RD_IDLE;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= {AXIL_DATA_WIDTH{1'b0}};
      seed_q        <= 8'h01;
      taps_q        <= 8'h00;
      running_q     <= 1'b0;
      div_q         <= {DIV_W{1'b0}};
      clr_act_q     <= 1'b0;
      clr_idx_q     <= 3'd0;
      samp_vld_q    <= 1'b0;
      rmw_pend_q    <= 1'b0;
      rmw_addr_q    <= {RAM_ADDR_WIDTH{1'b0}};
      rmw_cnt_q     <= {RAM_DATA_WIDTH{1'b0}};
      debug_rdata_q <= {RAM_DATA_WIDTH{1'b0}};
    end else begin
      wr_state_q    <= wr_state_d;
      awreg_q       <= awreg_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      rd_state_q    <= rd_state_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      seed_q        <= seed_d;
      taps_q        <= taps_d;
      running_q     <= running_d;
      div_q         <= div_d;
      clr_act_q     <= clr_act_d;
      clr_idx_q     <= clr_idx_d;
      samp_vld_q    <= samp_vld_d;
      rmw_pend_q    <= rmw_pend_d;
      rmw_addr_q    <= rmw_addr_d;
      rmw_cnt_q     <= rmw_cnt_d;
      debug_rdata_q <= debug_rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign debug_rdata   = debug_rdata_q;

endmodule

// File: tb/tb_histogram_system_top.sv
// Directed bench for histogram_system_top: register access, LFSR sample sequence,
// histogram counts against a bench-side LFSR model, debug port timing.
module tb_histogram_system_top;

`ifdef HIST_CLEAR_ON_START_EN
  localparam int CLR = 8;
`else
  localparam int CLR = 0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  s_axi_awaddr = 4'h0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = 32'h0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = 4'h0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [7:0]  debug_addr = 8'h0;
  logic        debug_rd_en = 1'b0;
  logic [31:0] debug_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] cnt_rd [8];
  logic [31:0] base [8];
  logic [31:0] exp_word [8];
  int delta [8];

  histogram_system_top dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .debug_addr(debug_addr), .debug_rd_en(debug_rd_en), .debug_rdata(debug_rdata)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [7:0] m_next(input logic [7:0] s, input logic [7:0] t);
    return s[0] ? ((s >> 1) ^ t) : (s >> 1);
  endfunction

  function automatic int m_bin(input logic [7:0] v);
    if (v <= 8'd32) return 0;
    return (int'(v) - 1) / 32;
  endfunction

  // Expected per-bin increments for n samples from seed 0x01, taps 0x8E.
  task automatic model_counts(input int n);
    logic [7:0] s;
    s = 8'h01;
    for (int b = 0; b < 8; b++) delta[b] = 0;
    for (int i = 0; i < n; i++) begin
      s = m_next(s, 8'h8E);
      delta[m_bin(s)]++;
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           output int w_edge, output logic [1:0] resp, output bit ok);
    int k;
    ok = 1'b1; resp = 2'b11; w_edge = 0;
    @(negedge aclk);
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    k = 0;
    while (!s_axi_awready && k < 50) begin @(negedge aclk); k++; end
    if (k >= 50) ok = 1'b0;
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_wdata = d; s_axi_wvalid = 1'b1;
    k = 0;
    while (!s_axi_wready && k < 50) begin @(negedge aclk); k++; end
    if (k >= 50) ok = 1'b0;
    @(negedge aclk);
    w_edge = cyc;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    k = 0;
    while (!s_axi_bvalid && k < 50) begin @(negedge aclk); k++; end
    if (k >= 50) ok = 1'b0;
    resp = s_axi_bresp;
    @(negedge aclk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    int k;
    ok = 1'b1; d = 32'hDEAD_BEEF; resp = 2'b11;
    @(negedge aclk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    k = 0;
    while (!s_axi_arready && k < 50) begin @(negedge aclk); k++; end
    if (k >= 50) ok = 1'b0;
    @(negedge aclk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    k = 0;
    while (!s_axi_rvalid && k < 50) begin @(negedge aclk); k++; end
    if (k >= 50) ok = 1'b0;
    d = s_axi_rdata; resp = s_axi_rresp;
    @(negedge aclk);
    s_axi_rready = 1'b0;
  endtask

  task automatic dbg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge aclk);
    debug_addr = a; debug_rd_en = 1'b1;
    @(negedge aclk);
    d = debug_rdata; debug_rd_en = 1'b0;
  endtask

  task automatic read_counts();
    logic [31:0] v;
    for (int b = 0; b < 8; b++) begin
      dbg_read(8'(b * 4), v);
      cnt_rd[b] = v;
    end
  endtask

  task automatic take_base();
`ifdef HIST_CLEAR_ON_START_EN
    for (int b = 0; b < 8; b++) base[b] = 32'h0;
`else
    read_counts();
    for (int b = 0; b < 8; b++) base[b] = cnt_rd[b];
`endif
  endtask

  task automatic check_counts(input string tag);
    read_counts();
    for (int b = 0; b < 8; b++) begin
      exp_word[b] = base[b] + 32'(delta[b]);
      total++;
      if (cnt_rd[b] !== exp_word[b]) begin
        bad++;
        $display("FAIL %s bin%0d: got %0d expected %0d", tag, b, cnt_rd[b], exp_word[b]);
      end
    end
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [31:0] expv, input string tag);
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_read(a, d, r, ok);
    total++;
    if (!ok || d !== expv || r !== 2'b00) begin
      bad++;
      $display("FAIL %s: got data=%h resp=%0d ok=%0d expected data=%h resp=0", tag, d, r, ok, expv);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input string tag, output int e);
    logic [1:0] r; bit ok;
    axi_write(a, d, e, r, ok);
    total++;
    if (!ok || r !== 2'b00) begin
      bad++;
      $display("FAIL %s: bresp=%0d ok=%0d expected bresp=0 ok=1", tag, r, ok);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_handshake: got %b expected 00000",
               {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid});
    end
    total++;
    if (s_axi_rdata !== 32'h0 || debug_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: rdata=%h debug=%h expected 0", s_axi_rdata, debug_rdata);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    check_reg(4'h0, 32'h0, "reset_start_reg");
    check_reg(4'h8, 32'h1, "reset_seed_reg");
    check_reg(4'hC, 32'h0, "reset_taps_reg");
  endtask

  task automatic test_registers();
    int e;
    do_write(4'h8, 32'h0000_0001, "wr_seed", e);
    check_reg(4'h8, 32'h1, "seed_rb");
    do_write(4'hC, 32'h0000_008E, "wr_taps", e);
    check_reg(4'hC, 32'h8E, "taps_rb");
    check_reg(4'h4, 32'h0, "stop_reads_zero");
  endtask

  // START then STOP timed so exactly three samples (0x8E, 0x47, 0xAD) are produced.
  task automatic test_first_samples();
    int e0, es;
    take_base();
    do_write(4'h0, 32'h1, "start1", e0);
    repeat (9 + CLR) @(negedge aclk);
    do_write(4'h4, 32'h1, "stop1", es);
    total++;
    if (es - e0 !== 13 + CLR) begin
      bad++;
      $display("FAIL first_window: got %0d clocks expected %0d", es - e0, 13 + CLR);
    end
    repeat (10) @(negedge aclk);
    for (int b = 0; b < 8; b++) delta[b] = 0;
    delta[4] = 1; delta[2] = 1; delta[5] = 1;
    check_counts("first_samples");
    check_reg(4'h0, 32'h0, "stopped_running");
  endtask

  task automatic test_long_run();
    int e0, es, n;
    logic [31:0] sum;
    logic [31:0] snap [8];
    take_base();
    do_write(4'h0, 32'h1, "start2", e0);
    check_reg(4'h0, 32'h1, "running_flag");
    for (int i = 0; i < 2500; i++) begin
      @(negedge aclk);
      debug_rd_en = ($urandom_range(0, 1) == 1);
      debug_addr  = 8'($urandom_range(0, 255));
    end
    @(negedge aclk);
    debug_rd_en = 1'b0;
    do_write(4'h4, 32'h1, "stop2", es);
    repeat (100) @(negedge aclk);
    n = (es - e0 - CLR) / 4;
    model_counts(n);
    check_counts("long_run");
    sum = 32'h0;
    for (int b = 0; b < 8; b++) sum = sum + (cnt_rd[b] - base[b]);
    total++;
    if (sum !== 32'(n)) begin
      bad++;
      $display("FAIL sample_sum: got %0d expected %0d", sum, n);
    end
    for (int b = 0; b < 8; b++) snap[b] = exp_word[b];
    repeat (100) @(negedge aclk);
    read_counts();
    for (int b = 0; b < 8; b++) begin
      total++;
      if (cnt_rd[b] !== snap[b]) begin
        bad++;
        $display("FAIL idle_stable bin%0d: got %0d expected %0d", b, cnt_rd[b], snap[b]);
      end
    end
  endtask

  task automatic test_debug_timing();
    @(negedge aclk);
    debug_addr = 8'd0; debug_rd_en = 1'b1;
    @(negedge aclk);
    debug_addr = 8'd4;
    @(negedge aclk);
    total++;
    if (debug_rdata !== exp_word[1]) begin
      bad++;
      $display("FAIL debug_latency: got %0d expected %0d", debug_rdata, exp_word[1]);
    end
    debug_rd_en = 1'b0; debug_addr = 8'd16;
    repeat (2) @(negedge aclk);
    total++;
    if (debug_rdata !== exp_word[1]) begin
      bad++;
      $display("FAIL debug_hold: got %0d expected %0d", debug_rdata, exp_word[1]);
    end
  endtask

  task automatic test_seed_zero_restart();
    int e0, es, n;
    do_write(4'h8, 32'h0, "wr_seed0", e0);
    check_reg(4'h8, 32'h1, "seed0_stored_as_1");
    take_base();
    do_write(4'h0, 32'h1, "start3", e0);
`ifdef HIST_CLEAR_ON_START_EN
    begin
      logic [31:0] v;
      logic [7:0] wl [4];
      wl[0] = 8'd16; wl[1] = 8'd8; wl[2] = 8'd20; wl[3] = 8'd0;
      repeat (8) @(negedge aclk);
      for (int i = 0; i < 4; i++) begin
        dbg_read(wl[i], v);
        total++;
        if (v !== 32'h0) begin
          bad++;
          $display("FAIL cleared_word%0d: got %0d expected 0", wl[i], v);
        end
      end
    end
`endif
    repeat (40) @(negedge aclk);
    do_write(4'h4, 32'h1, "stop3", es);
    repeat (20) @(negedge aclk);
    n = (es - e0 - CLR) / 4;
    model_counts(n);
    check_counts("restart");
  endtask

  initial begin
    test_reset();
    test_registers();
    test_first_samples();
    test_long_run();
    test_debug_timing();
    test_seed_zero_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
